multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM sequencing the 16-bit gigaHurt datapath as a multicycle CPU with one shared memory port.
//  Decodes op = instr[15:13] and funct = instr[3:0] from the instruction register.
//  Issues per-state datapath enables, mux selects and alucontrol.
//  Handshakes with memory: mem_req out, mem_ready in.
// PARAMETERS
//  N          16   datapath width; sets the counter width when the optional feature is compiled in
//  ALU_ADD    4'b0010  alucontrol code for address calc, PC+2 and addi
//  ALU_SUB    4'b0110  alucontrol code for beq/bne compare
// PORTS
//  clk         input   1   rising-edge clock
//  reset       input   1   asynchronous, active-low reset (0 = reset)
//  op          input   3   opcode: 000 R, 001 lw, 010 sw, 011 beq, 100 addi, 101 j, 110 bne, 111 illegal
//  funct       input   4   R-type ALU function; passed straight to alucontrol in EXEC
//  zero        input   1   ALU zero flag
//  mem_ready   input   1   memory done with current access
//  mem_req     output  1   memory access request
//  iord        output  1   memory address select: 0 = pc, 1 = aluout
//  memwrite    output  1   memory write strobe
//  irwrite     output  1   load instruction register
//  pcen        output  1   PC load enable
//  pcsrc       output  2   PC source: 00 = ALU result, 01 = aluout (branch target), 10 = jump target
//  regdst      output  1   write-register select: 1 = rd, 0 = rt
//  memtoreg    output  1   register writeback from memory data
//  regwrite    output  1   register file write enable
//  alusrca     output  1   ALU A select: 0 = pc, 1 = register A
//  alusrcb     output  2   ALU B select: 00 = regB, 01 = const 2, 10 = signimm, 11 = signimm<<1
//  alucontrol  output  4   ALU operation
//  illegal     output  1   illegal opcode trapped (sticky)
//  state       output  4   current state encoding, for debug
// BEHAVIOUR
//  - Reset (reset = 0, async): state <= FETCH; every output = 0 while reset is held.
//    This includes mem_req and state (FETCH = 4'd0).
//  - Reset asserted mid-access: the access is abandoned; no write strobe is asserted after reset.
//  - First cycle after reset release: FETCH with mem_req = 1.
//  - Outputs are decoded from state only (Moore), except pcen, irwrite and memwrite, which also use mem_ready/zero as listed.
//  - States and outputs (all unlisted outputs = 0):
//    - FETCH(0): mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=ALU_ADD, pcsrc=00.
//      - irwrite=pcen=mem_ready.
//      - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
//    - DECODE(1): alusrca=0, alusrcb=11, alucontrol=ALU_ADD (precomputes branch target into aluout).
//      - Next state by op: 001/010 -> MEMADR, 000 -> EXEC, 011/110 -> BRANCH, 100 -> ADDIEX, 101 -> JUMP, 111 -> HALT.
//    - MEMADR(2): alusrca=1, alusrcb=10, ALU_ADD. Next: lw -> MEMRD, sw -> MEMWR.
//    - MEMRD(3): mem_req=1, iord=1. Holds while mem_ready=0, then -> MEMWB.
//    - MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//    - MEMWR(5): mem_req=1, iord=1, memwrite=mem_ready. Holds while mem_ready=0, then -> FETCH.
//    - EXEC(6): alusrca=1, alusrcb=00, alucontrol=funct -> ALUWB.
//    - ALUWB(7): regdst=1, regwrite=1 -> FETCH.
//    - BRANCH(8): alusrca=1, alusrcb=00, ALU_SUB, pcsrc=01.
//      - pcen = zero (beq) or ~zero (bne). Then -> FETCH.
//    - ADDIEX(9): alusrca=1, alusrcb=10, ALU_ADD -> ADDIWB.
//    - ADDIWB(10): regdst=0, regwrite=1 -> FETCH.
//    - JUMP(11): pcsrc=10, pcen=1 -> FETCH.
//    - HALT(12): illegal=1. No enables asserted. Stays in HALT until reset.
//  - Codes 13-15 are unreachable; if entered, the next state is HALT.
//  - mem_req stays high and the state and all selects stay stable until mem_ready is sampled 1.
//    mem_ready is ignored in states without mem_req.
//  - CPI: R/addi 4, lw 5, sw 4, beq/bne 3, j 3 (zero-wait memory); each memory wait cycle adds 1.
// CONFIGURATION
//  - MULTICYCLE_CTRL_PERF_EN defined: adds outputs cyc_cnt[N-1:0] and instret[N-1:0].
//    - cyc_cnt increments every cycle out of reset, except in HALT.
//    - instret increments on each entry to FETCH from a completing state (MEMWB, MEMWR done, ALUWB, BRANCH, ADDIWB, JUMP).
//    - Both counters reset to 0 and wrap modulo 2^N.
//  - MULTICYCLE_CTRL_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  - Reset, then release with mem_ready=1: FETCH shows mem_req=1, irwrite=1, pcen=1, alusrcb=01; DECODE on the next cycle.
//  - R-type op=000 funct=0110, zero-wait: states 0,1,6,7,0. alucontrol=0110 in EXEC; regdst=1, regwrite=1 in ALUWB.
//  - lw op=001 with mem_ready low 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. iord=1 throughout MEMRD; memtoreg=1, regwrite=1 in MEMWB.
//  - beq op=011 with zero=1, then zero=0: pcen=1/pcsrc=01 the first time, pcen=0 the second. bne op=110 gives the inverse.
//  - op=111: HALT with illegal=1; pcen, regwrite and memwrite stay 0 for 10 cycles. reset low recovers to FETCH with illegal=0.
//  - Async reset asserted mid-MEMWR between clock edges: all outputs 0 immediately; no memwrite pulse; FETCH after release.
//    With PERF_EN, instret=0 after reset and counts 3 after executing R, sw, j.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and the shared memory port.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic memwrite;

  modport master (output mem_req, output iord, output memwrite, input mem_ready);
  modport slave  (input mem_req, input iord, input memwrite, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the 16-bit gigaHurt multicycle datapath over one shared memory port.
// Optional cycle/retired-instruction counters: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_controller #(
  parameter int          N       = 16,
  parameter logic [3:0]  ALU_ADD = 4'b0010,
  parameter logic [3:0]  ALU_SUB = 4'b0110
) (
  input  logic        clk,
  input  logic        reset,
  multicycle_controller_if.master mem,
  input  logic [2:0]  op,
  input  logic [3:0]  funct,
  input  logic        zero,
  output logic        irwrite,
  output logic        pcen,
  output logic [1:0]  pcsrc,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [3:0]  alucontrol,
  output logic        illegal,
  output logic [3:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [N-1:0] cyc_cnt,
  output logic [N-1:0] instret
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= FETCH;
    else        cur <= nxt;
  end

  // Outputs are forced low combinationally while reset is held, so an
  // access in flight is dropped without a trailing write strobe.
  always_comb begin
    nxt          = cur;
    mem.mem_req  = 1'b0;
    mem.iord     = 1'b0;
    mem.memwrite = 1'b0;
    irwrite      = 1'b0;
    pcen         = 1'b0;
    pcsrc        = '0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = '0;
    alucontrol   = '0;
    illegal      = 1'b0;
    state        = reset ? cur : '0;
    if (reset) begin
      case (cur)
        FETCH: begin
          mem.mem_req = 1'b1;
          alusrcb     = 2'b01;
          alucontrol  = ALU_ADD;
          irwrite     = mem.mem_ready;
          pcen        = mem.mem_ready;
          if (mem.mem_ready) nxt = DECODE;
        end
        DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          case (op)
            3'b000:         nxt = EXEC;
            3'b001, 3'b010: nxt = MEMADR;
            3'b011, 3'b110: nxt = BRANCH;
            3'b100:         nxt = ADDIEX;
            3'b101:         nxt = JUMP;
            default:        nxt = HALT;
          endcase
        end
        MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          nxt        = (op == 3'b010) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
          if (mem.mem_ready) nxt = MEMWB;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        MEMWR: begin
          mem.mem_req  = 1'b1;
          mem.iord     = 1'b1;
          mem.memwrite = mem.mem_ready;
          if (mem.mem_ready) nxt = FETCH;
        end
        EXEC: begin
          alusrca    = 1'b1;
          alucontrol = funct;
          nxt        = ALUWB;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcen       = (op == 3'b110) ? ~zero : zero;
          nxt        = FETCH;
        end
        ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          nxt        = ADDIWB;
        end
        ADDIWB: begin
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        JUMP: begin
          pcsrc = 2'b10;
          pcen  = 1'b1;
          nxt   = FETCH;
        end
        HALT: begin
          illegal = 1'b1;
          nxt     = HALT;
        end
        default: nxt = HALT;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    if (nxt == FETCH)
      retire = (cur == MEMWB) || (cur == MEMWR) || (cur == ALUWB) ||
               (cur == BRANCH) || (cur == ADDIWB) || (cur == JUMP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      instret <= '0;
    end else begin
      if (cur != HALT) cyc_cnt <= cyc_cnt + N'(1);
      if (retire)      instret <= instret + N'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: every cycle's full output vector is checked.
module tb_multicycle_controller;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  funct = '0;
  logic        zero = 1'b0;
  logic        irwrite, pcen, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0]  pcsrc, alusrcb;
  logic [3:0]  alucontrol, state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [15:0] cyc_cnt, instret;
`endif

  multicycle_controller_if mem_bus ();

  multicycle_controller #(.N(16), .ALU_ADD(4'b0010), .ALU_SUB(4'b0110)) dut (
    .clk(clk), .reset(reset), .mem(mem_bus), .op(op), .funct(funct), .zero(zero),
    .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected outputs for a state; 'live' is the handshake/zero-dependent enable of that state.
  function automatic logic [21:0] ex(input logic [3:0] st, input logic live, input logic [3:0] fn);
    logic       mreq = 1'b0, iord = 1'b0, mw = 1'b0, irw = 1'b0, pe = 1'b0;
    logic       rd = 1'b0, m2r = 1'b0, rw = 1'b0, asa = 1'b0, ill = 1'b0;
    logic [1:0] ps = 2'b00, asb = 2'b00;
    logic [3:0] ac = 4'b0000;
    case (st)
      4'd0:  begin mreq = 1'b1; irw = live; pe = live; asb = 2'b01; ac = ADD; end
      4'd1:  begin asb = 2'b11; ac = ADD; end
      4'd2:  begin asa = 1'b1; asb = 2'b10; ac = ADD; end
      4'd3:  begin mreq = 1'b1; iord = 1'b1; end
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin mreq = 1'b1; iord = 1'b1; mw = live; end
      4'd6:  begin asa = 1'b1; asb = 2'b00; ac = fn; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; ac = SUB; ps = 2'b01; pe = live; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; ac = ADD; end
      4'd10: begin rw = 1'b1; end
      4'd11: begin ps = 2'b10; pe = 1'b1; end
      4'd12: begin ill = 1'b1; end
      default: ;
    endcase
    return {mreq, iord, mw, irw, pe, ps, rd, m2r, rw, asa, asb, ac, ill, st};
  endfunction

  function automatic logic [21:0] observed();
    return {mem_bus.mem_req, mem_bus.iord, mem_bus.memwrite, irwrite, pcen, pcsrc, regdst,
            memtoreg, regwrite, alusrca, alusrcb, alucontrol, illegal, state};
  endfunction

  task automatic push(input string tag, input logic [21:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [21:0] o;
    e = sb.pop_front();
    o = observed();
    checks++;
    assert (o === e.vec) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, o, e.vec);
    end
  endtask

  // Drive inputs on the falling edge, record the expectation, sample 1 ns later.
  task automatic step(input string tag, input logic mr, input logic z, input logic [21:0] v);
    @(negedge clk);
    mem_bus.mem_ready = mr;
    zero = z;
    push(tag, v);
    #1 check_out();
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  task automatic check_cnt(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    step("reset_hold", 1'b1, 1'b0, '0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_cnt("reset_cyc", cyc_cnt, 16'd0);
    check_cnt("reset_instret", instret, 16'd0);
`endif
    mem_bus.mem_ready = 1'b0;
    reset = 1'b1;

    // R-type, zero wait
    op = 3'b000; funct = 4'b0110;
    step("fetch_wait", 1'b0, 1'b0, ex(4'd0, 1'b0, 4'd0));
    step("fetch",      1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("r_decode",   1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("r_exec",     1'b1, 1'b0, ex(4'd6, 1'b0, 4'b0110));
    step("r_aluwb",    1'b1, 1'b0, ex(4'd7, 1'b0, 4'd0));

    // lw with two wait cycles in MEMRD
    op = 3'b001;
    step("lw_fetch",   1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("lw_decode",  1'b0, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("lw_memadr",  1'b0, 1'b0, ex(4'd2, 1'b0, 4'd0));
    step("lw_memrd0",  1'b0, 1'b0, ex(4'd3, 1'b0, 4'd0));
    step("lw_memrd1",  1'b0, 1'b0, ex(4'd3, 1'b0, 4'd0));
    step("lw_memrd2",  1'b1, 1'b0, ex(4'd3, 1'b0, 4'd0));
    step("lw_memwb",   1'b1, 1'b0, ex(4'd4, 1'b0, 4'd0));

    // beq taken / not taken
    op = 3'b011;
    step("beq_fetch",  1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("beq_decode", 1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("beq_z1",     1'b1, 1'b1, ex(4'd8, 1'b1, 4'd0));
    step("beq_fetch2", 1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("beq_decode2",1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("beq_z0",     1'b1, 1'b0, ex(4'd8, 1'b0, 4'd0));

    // bne gives the inverse
    op = 3'b110;
    step("bne_fetch",  1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("bne_decode", 1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("bne_z1",     1'b1, 1'b1, ex(4'd8, 1'b0, 4'd0));
    step("bne_fetch2", 1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("bne_decode2",1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("bne_z0",     1'b1, 1'b0, ex(4'd8, 1'b1, 4'd0));

    // addi
    op = 3'b100;
    step("addi_fetch", 1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("addi_decode",1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("addi_ex",    1'b1, 1'b0, ex(4'd9, 1'b0, 4'd0));
    step("addi_wb",    1'b1, 1'b0, ex(4'd10, 1'b0, 4'd0));

    // sw with one wait cycle
    op = 3'b010;
    step("sw_fetch",   1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("sw_decode",  1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("sw_memadr",  1'b1, 1'b0, ex(4'd2, 1'b0, 4'd0));
    step("sw_memwr0",  1'b0, 1'b0, ex(4'd5, 1'b0, 4'd0));
    step("sw_memwr1",  1'b1, 1'b0, ex(4'd5, 1'b1, 4'd0));

    // jump
    op = 3'b101;
    step("j_fetch",    1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("j_decode",   1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("j_jump",     1'b1, 1'b0, ex(4'd11, 1'b0, 4'd0));

    // illegal opcode traps in HALT regardless of mem_ready/zero
    op = 3'b111;
    step("ill_fetch",  1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("ill_decode", 1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    for (int i = 0; i < 10; i++)
      step("halt", 1'(i % 2), 1'(1 - (i % 2)), ex(4'd12, 1'b0, 4'd0));
    #2 reset = 1'b0;
    push("halt_async_reset", '0);
    #1 check_out();
    step("halt_reset_hold", 1'b0, 1'b0, '0);
    reset = 1'b1;

    // async reset mid-MEMWR, arriving together with mem_ready
    op = 3'b010;
    step("recover_fetch", 1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("sw2_decode",    1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("sw2_memadr",    1'b1, 1'b0, ex(4'd2, 1'b0, 4'd0));
    step("sw2_memwr",     1'b0, 1'b0, ex(4'd5, 1'b0, 4'd0));
    #2 mem_bus.mem_ready = 1'b1;
    reset = 1'b0;
    push("memwr_async_reset", '0);
    #1 check_out();
    step("memwr_reset_hold", 1'b1, 1'b0, '0);
    step("memwr_reset_hold2", 1'b0, 1'b0, '0);
    reset = 1'b1;
    step("post_reset_fetch", 1'b0, 1'b0, ex(4'd0, 1'b0, 4'd0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_cnt("instret_after_reset", instret, 16'd0);
`endif

    // R, sw, j after reset: three retirements
    op = 3'b000; funct = 4'b0111;
    step("p_r_fetch",  1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("p_r_decode", 1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("p_r_exec",   1'b1, 1'b0, ex(4'd6, 1'b0, 4'b0111));
    step("p_r_aluwb",  1'b1, 1'b0, ex(4'd7, 1'b0, 4'd0));
    op = 3'b010;
    step("p_sw_fetch", 1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("p_sw_decode",1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("p_sw_memadr",1'b1, 1'b0, ex(4'd2, 1'b0, 4'd0));
    step("p_sw_memwr", 1'b1, 1'b0, ex(4'd5, 1'b1, 4'd0));
    op = 3'b101;
    step("p_j_fetch",  1'b1, 1'b0, ex(4'd0, 1'b1, 4'd0));
    step("p_j_decode", 1'b1, 1'b0, ex(4'd1, 1'b0, 4'd0));
    step("p_j_jump",   1'b1, 1'b0, ex(4'd11, 1'b0, 4'd0));
    step("p_final_fetch", 1'b0, 1'b0, ex(4'd0, 1'b0, 4'd0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_cnt("instret_r_sw_j", instret, 16'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
